// File: rtl/vram_pixel_streamer_if.sv
// Word-read bus toward data_ram's VGA port and the serial pixel bus toward the display.
interface vram_pixel_streamer_if #(
  parameter int N  = 8,
  parameter int R  = 6,
  parameter int AW = 17
);
  logic [AW-1:0]       a_vga;
  logic [R-1:0][N-1:0] vram_i;
  logic                pixel_ready;
  logic [N-1:0]        pixel_o;
  logic                pixel_vld;

  modport master (output a_vga, input vram_i, input pixel_ready, output pixel_o, output pixel_vld);
  modport slave  (input a_vga, output vram_i, output pixel_ready, input pixel_o, input pixel_vld);
endinterface

// File: rtl/vram_pixel_streamer.sv
// Prefetches R-lane VRAM words into a small FIFO and serialises them one pixel per pixel_ready.
// Optional macro VPS_UFLOW_CNT_EN adds a saturating 16-bit underflow event counter output.
module vram_pixel_streamer #(
  parameter int          N         = 8,
  parameter int          R         = 6,
  parameter int          AW        = 17,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          NPIX      = 65536,
  parameter int          RD_LAT    = 1,
  parameter int          FIFO_D    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  vram_pixel_streamer_if.master bus,
  output logic                  frame_done,
  output logic                  underflow
`ifdef VPS_UFLOW_CNT_EN
  ,
  output logic [15:0]           uflow_cnt
`endif
);
  localparam int NWORDS = (NPIX + R - 1) / R;
  localparam int LW     = (R > 1) ? $clog2(R) : 1;
  localparam int PW     = $clog2(NPIX + 1);
  localparam int WW     = $clog2(NWORDS + 1);
  localparam int FPW    = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int FCW    = $clog2(FIFO_D + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  if (longint'(BASE_ADDR) + longint'(NWORDS) - 1 > (longint'(1) << AW) - 1) begin : g_addr_chk
    $error("vram_pixel_streamer: frame does not fit in AW-bit address space");
  end
  if ((FIFO_D < 2) || ((FIFO_D & (FIFO_D - 1)) != 0)) begin : g_fifo_chk
    $error("vram_pixel_streamer: FIFO_D must be a power of 2 >= 2");
  end

  logic [1:0]          state_q, state_d;
  logic [WW-1:0]       issued_q, issued_d;
  logic [RD_LAT-1:0]   tag_q, tag_d;
  logic [AW-1:0]       a_q, a_d;
  logic [R-1:0][N-1:0] mem_q [FIFO_D];
  logic [FPW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [FCW-1:0]      cnt_q, cnt_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [PW-1:0]       pix_cnt_q, pix_cnt_d;
  logic [N-1:0]        pix_q, pix_d;
  logic                vld_q, vld_d;
  logic                done_q, done_d;
  logic                uflow_q, uflow_d;
`ifdef VPS_UFLOW_CNT_EN
  logic [15:0]         ucnt_q, ucnt_d;
`endif

  logic [7:0]          infl;
  logic                room, issue, capture, fire, starve, last_pix, pop;
  logic [R-1:0][N-1:0] head;

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) infl = infl + 8'(tag_q[i]);
  end

  // Issue only when every outstanding read is guaranteed a FIFO slot on return.
  assign room     = (32'(cnt_q) + 32'(infl)) < 32'(FIFO_D);
  assign issue    = frame_start || (state_q == S_FILL && room && 32'(issued_q) < NWORDS);
  assign capture  = tag_q[RD_LAT-1] && !frame_start;
  assign head     = mem_q[rd_q];
  assign fire     = bus.pixel_ready && !frame_start && (cnt_q != '0) && !done_q;
  assign starve   = bus.pixel_ready && !frame_start && (cnt_q == '0) && !done_q;
  assign last_pix = 32'(pix_cnt_q) == NPIX - 1;
  assign pop      = fire && ((32'(lane_q) == R - 1) || last_pix);

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    a_d       = a_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    pix_cnt_d = pix_cnt_q;
    pix_d     = pix_q;
    vld_d     = 1'b0;
    done_d    = done_q;
    uflow_d   = uflow_q;
`ifdef VPS_UFLOW_CNT_EN
    ucnt_d    = ucnt_q;
`endif
    tag_d     = '0;
    tag_d[0]  = issue;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];

    if (frame_start) begin
      // Flush drops all in-flight tags; only the read issued now survives.
      tag_d     = '0;
      tag_d[0]  = 1'b1;
      state_d   = S_FILL;
      issued_d  = WW'(1);
      a_d       = AW'(BASE_ADDR);
      wr_d      = '0;
      rd_d      = '0;
      cnt_d     = '0;
      lane_d    = '0;
      pix_cnt_d = '0;
      done_d    = 1'b0;
      uflow_d   = 1'b0;
`ifdef VPS_UFLOW_CNT_EN
      ucnt_d    = '0;
`endif
      if (bus.pixel_ready) pix_d = '0;
    end else begin
      if (issue) begin
        a_d      = AW'(BASE_ADDR) + AW'(issued_q);
        issued_d = issued_q + WW'(1);
      end
      case (state_q)
        S_FILL:   if (32'(issued_q) == NWORDS) state_d = S_STREAM;
        S_STREAM: if (done_q) state_d = S_IDLE;
        default:  ;
      endcase
      if (capture) wr_d = wr_q + FPW'(1);
      if (pop)     rd_d = rd_q + FPW'(1);
      cnt_d = cnt_q + FCW'(capture) - FCW'(pop);

      if (fire) begin
        pix_d     = head[lane_q];
        vld_d     = 1'b1;
        pix_cnt_d = pix_cnt_q + PW'(1);
        lane_d    = pop ? '0 : lane_q + LW'(1);
        done_d    = last_pix;
      end else if (starve) begin
        pix_d   = '0;
        uflow_d = 1'b1;
`ifdef VPS_UFLOW_CNT_EN
        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
`endif
      end else if (bus.pixel_ready) begin
        pix_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      issued_q  <= '0;
      tag_q     <= '0;
      a_q       <= AW'(BASE_ADDR);
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      lane_q    <= '0;
      pix_cnt_q <= '0;
      pix_q     <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      uflow_q   <= 1'b0;
`ifdef VPS_UFLOW_CNT_EN
      ucnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      tag_q     <= tag_d;
      a_q       <= a_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      pix_cnt_q <= pix_cnt_d;
      pix_q     <= pix_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      uflow_q   <= uflow_d;
`ifdef VPS_UFLOW_CNT_EN
      ucnt_q    <= ucnt_d;
`endif
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q/pointers alone.
  always_ff @(posedge clk) begin
    if (capture && !reset) mem_q[wr_q] <= bus.vram_i;
  end

  assign bus.a_vga     = a_d;
  assign bus.pixel_o   = pix_q;
  assign bus.pixel_vld = vld_q;
  assign frame_done    = done_q;
  assign underflow     = uflow_q;
`ifdef VPS_UFLOW_CNT_EN
  assign uflow_cnt     = ucnt_q;
`endif
endmodule

// File: tb/tb_vram_pixel_streamer.sv
// Self-checking bench: hashed VRAM contents, pixel-index reference model, randomized pixel_ready.
`timescale 1ns/1ps
module tb_vram_pixel_streamer;
  localparam int N = 8, R = 6, AW = 17, BASE = 100, NPIX = 1000, RD_LAT = 1, FIFO_D = 4;
  localparam int NWORDS    = (NPIX + R - 1) / R;
  localparam int LAST_ADDR = BASE + NWORDS - 1;

  logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0;
  logic frame_done, underflow;
`ifdef VPS_UFLOW_CNT_EN
  logic [15:0] uflow_cnt;
  logic [15:0] o_ucnt;
`endif

  vram_pixel_streamer_if #(.N(N), .R(R), .AW(AW)) bus ();

  vram_pixel_streamer #(
    .N(N), .R(R), .AW(AW), .BASE_ADDR(BASE), .NPIX(NPIX), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bus(bus),
    .frame_done(frame_done), .underflow(underflow)
`ifdef VPS_UFLOW_CNT_EN
    , .uflow_cnt(uflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned seed;
  int total = 0, bad = 0, fk = 0;
  logic [AW-1:0] o_a;
  logic [N-1:0]  o_pix;
  logic          o_vld, o_done, o_uf;

  function automatic logic [N-1:0] pix_at(input int unsigned addr, input int unsigned lane);
    int unsigned h;
    h = (addr * 32'd2654435761) ^ (lane * 32'd40503) ^ seed;
    h = h ^ (h >> 13);
    return h[N-1:0];
  endfunction

  function automatic logic [N-1:0] exp_pix(input int p);
    return pix_at(BASE + p / R, p % R);
  endfunction

  // data_ram read port: one-cycle registered latency
  always @(posedge clk)
    for (int l = 0; l < R; l++) bus.vram_i[l] <= pix_at(bus.a_vga, l);

  always @(negedge clk)
    if (!reset && dut.capture && dut.cnt_q == FIFO_D) begin
      bad++;
      $display("FAIL fifo_overrun capture with cnt=%0d limit=%0d", dut.cnt_q, FIFO_D);
    end

  task automatic cyc(input logic fs, input logic pr);
    frame_start     = fs;
    bus.pixel_ready = pr;
    @(negedge clk);
    o_a = bus.a_vga; o_pix = bus.pixel_o; o_vld = bus.pixel_vld;
    o_done = frame_done; o_uf = underflow;
`ifdef VPS_UFLOW_CNT_EN
    o_ucnt = uflow_cnt;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b0; bus.pixel_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cyc(0, 0);
    total++; if (o_a !== AW'(BASE)) begin bad++; $display("FAIL reset_a_vga got=%0d want=%0d", o_a, BASE); end
    total++; if (o_pix !== '0) begin bad++; $display("FAIL reset_pixel got=%0h want=0", o_pix); end
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", o_vld); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
    total++; if (o_uf !== 1'b0) begin bad++; $display("FAIL reset_uflow got=%b want=0", o_uf); end
`ifdef VPS_UFLOW_CNT_EN
    total++; if (o_ucnt !== 16'd0) begin bad++; $display("FAIL reset_ucnt got=%0d want=0", o_ucnt); end
`endif
  endtask

  task automatic test_prefetch();
    cyc(1, 0);
    total++; if (o_a !== AW'(BASE)) begin bad++; $display("FAIL pf_addr0 got=%0d want=%0d", o_a, BASE); end
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0);
      total++; if (o_a !== AW'(BASE + i)) begin bad++; $display("FAIL pf_addr%0d got=%0d want=%0d", i, o_a, BASE + i); end
    end
    cyc(0, 0);
    total++; if (o_a !== AW'(BASE + 3)) begin bad++; $display("FAIL pf_hold got=%0d want=%0d", o_a, BASE + 3); end
    repeat (3) cyc(0, 0);
    cyc(0, 1);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1);
      total++;
      if (o_vld !== 1'b1 || o_pix !== exp_pix(k)) begin
        bad++; $display("FAIL pf_pix%0d got=%0h/%b want=%0h/1", k, o_pix, o_vld, exp_pix(k));
      end
    end
    cyc(0, 0);
    total++; if (o_uf !== 1'b0) begin bad++; $display("FAIL pf_uflow got=%b want=0", o_uf); end
  endtask

  task automatic test_full_frame();
    int k = 0, maxa = 0;
    cyc(1, 0);
    repeat (8) cyc(0, 0);
    for (int c = 0; c < 12 * NPIX && !o_done; c++) begin
      cyc(0, $urandom_range(3) == 0);
      if (int'(o_a) > maxa) maxa = int'(o_a);
      if (o_vld) begin
        total++;
        if (o_pix !== exp_pix(k)) begin
          bad++; $display("FAIL ff_pix%0d got=%0h want=%0h", k, o_pix, exp_pix(k));
        end
        k++;
      end
    end
    total++; if (k != NPIX) begin bad++; $display("FAIL ff_count got=%0d want=%0d", k, NPIX); end
    total++; if (o_done !== 1'b1) begin bad++; $display("FAIL ff_done got=%b want=1", o_done); end
    total++; if (o_uf !== 1'b0) begin bad++; $display("FAIL ff_uflow got=%b want=0", o_uf); end
    total++; if (maxa != LAST_ADDR) begin bad++; $display("FAIL ff_maxaddr got=%0d want=%0d", maxa, LAST_ADDR); end
  endtask

  task automatic test_after_done();
    cyc(0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1);
      total++;
      if (o_vld !== 1'b0 || o_pix !== '0 || o_uf !== 1'b0 || o_done !== 1'b1) begin
        bad++; $display("FAIL ad_cyc%0d got vld=%b pix=%0h uf=%b done=%b want 0/0/0/1", i, o_vld, o_pix, o_uf, o_done);
      end
    end
  endtask

  task automatic test_underflow();
    cyc(1, 0);
    cyc(0, 1);
    cyc(0, 1);
    total++; if (o_vld !== 1'b0 || o_pix !== '0) begin bad++; $display("FAIL uf_pix got=%0h/%b want=0/0", o_pix, o_vld); end
    total++; if (o_uf !== 1'b1) begin bad++; $display("FAIL uf_flag got=%b want=1", o_uf); end
`ifdef VPS_UFLOW_CNT_EN
    total++; if (o_ucnt !== 16'd1) begin bad++; $display("FAIL uf_cnt got=%0d want=1", o_ucnt); end
`endif
    cyc(0, 0);
    total++; if (o_vld !== 1'b1 || o_pix !== exp_pix(0)) begin bad++; $display("FAIL uf_first got=%0h/%b want=%0h/1", o_pix, o_vld, exp_pix(0)); end
    fk = 1;
  endtask

  task automatic test_flush_midframe();
    for (int c = 0; c < 8 * 300 && fk < 300; c++) begin
      cyc(0, $urandom_range(3) == 0);
      if (o_vld) begin
        total++;
        if (o_pix !== exp_pix(fk)) begin bad++; $display("FAIL fl_pix%0d got=%0h want=%0h", fk, o_pix, exp_pix(fk)); end
        fk++;
      end
    end
    cyc(0, 0);
    if (o_vld) fk++;
    total++; if (fk < 300) begin bad++; $display("FAIL fl_reach got=%0d want>=300", fk); end
    total++; if (o_uf !== 1'b1) begin bad++; $display("FAIL fl_uf_before got=%b want=1", o_uf); end
    cyc(1, 1);
    total++; if (o_a !== AW'(BASE)) begin bad++; $display("FAIL fl_addr got=%0d want=%0d", o_a, BASE); end
    cyc(0, 0);
    total++;
    if (o_vld !== 1'b0 || o_pix !== '0 || o_uf !== 1'b0 || o_done !== 1'b0) begin
      bad++; $display("FAIL fl_after got vld=%b pix=%0h uf=%b done=%b want 0/0/0/0", o_vld, o_pix, o_uf, o_done);
    end
    total++; if (o_a !== AW'(BASE + 1)) begin bad++; $display("FAIL fl_addr1 got=%0d want=%0d", o_a, BASE + 1); end
`ifdef VPS_UFLOW_CNT_EN
    total++; if (o_ucnt !== 16'd0) begin bad++; $display("FAIL fl_ucnt got=%0d want=0", o_ucnt); end
`endif
    repeat (6) cyc(0, 0);
    cyc(0, 1);
    cyc(0, 0);
    total++; if (o_vld !== 1'b1 || o_pix !== exp_pix(0)) begin bad++; $display("FAIL fl_first got=%0h/%b want=%0h/1", o_pix, o_vld, exp_pix(0)); end
  endtask

  task automatic test_reset_inflight();
    cyc(1, 0);
    reset = 1'b1;
    cyc(0, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0);
      total++;
      if (o_a !== AW'(BASE) || o_pix !== '0 || o_vld !== 1'b0 || o_done !== 1'b0 || o_uf !== 1'b0) begin
        bad++; $display("FAIL ri_cyc%0d got a=%0d pix=%0h vld=%b done=%b uf=%b want %0d/0/0/0/0", i, o_a, o_pix, o_vld, o_done, o_uf, BASE);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1);
      total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL ri_nopix%0d got=%b want=0", i, o_vld); end
    end
    cyc(1, 0);
    repeat (6) cyc(0, 0);
    cyc(0, 1);
    cyc(0, 0);
    total++; if (o_vld !== 1'b1 || o_pix !== exp_pix(0)) begin bad++; $display("FAIL ri_first got=%0h/%b want=%0h/1", o_pix, o_vld, exp_pix(0)); end
  endtask

  initial begin
    seed = $urandom;
    bus.pixel_ready = 1'b0;
    test_reset();
    test_prefetch();
    test_full_frame();
    test_after_done();
    test_underflow();
    test_flush_midframe();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
